trig_capture: RTL and testbench
===============================

TRIG_CAPTURE -- requirements
Module: trig_capture

Interface
REQ-001 Parameter DEPTH_LOG2, default 6, log2 of capture buffer depth in 128-bit words (DEPTH = 64).
REQ-002 Parameter PRE_WORDS, default 16, pre-trigger words kept; legal range 1..DEPTH-1.
REQ-003 clkin  input  1  single clock; all state changes on its rising edge (upstream generator drives on falling edge).
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 datain  input  128  sample word from signal generator: 16 x 8-bit samples.
REQ-006 trigin  input  1  trigger level from signal generator.
REQ-007 arm  input  1  single-cycle request to start a capture.
REQ-008 rd_en  input  1  readout request, one word per asserted cycle.
REQ-009 rd_data  output  128  buffer word being read out.
REQ-010 rd_valid  output  1  rd_data valid this cycle.
REQ-011 busy  output  1  high in PREFILL, ARMED, POST.
REQ-012 done  output  1  high in DONE (capture complete, readout pending).
REQ-013 trig_addr  output  DEPTH_LOG2  buffer address of the trigger word.

Function
REQ-014 States SHALL be IDLE, PREFILL, ARMED, POST, DONE; encoding is free.
REQ-015 trig_d SHALL register trigin every cycle in all states; trigger event = trigin=1 and trig_d=0.
REQ-016 IDLE: arm=1 -> PREFILL, wr_ptr <= 0, fill count <= 0; arm in any other state SHALL be ignored.
REQ-017 In PREFILL, ARMED, POST the block SHALL write datain to buffer[wr_ptr] every cycle and increment wr_ptr modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-018 PREFILL: after exactly PRE_WORDS writes -> ARMED; trigger events during PREFILL SHALL be ignored.
REQ-019 ARMED: buffer overwrites circularly; on a trigger event the word written that cycle is the trigger word, trig_addr <= wr_ptr, -> POST.
REQ-020 POST: after DEPTH-PRE_WORDS total writes counting the trigger word -> DONE; further trigger events ignored.
REQ-021 Entering DONE SHALL set rd_ptr <= (trig_addr - PRE_WORDS) mod DEPTH, read count <= 0.
REQ-022 DONE: each rd_en=1 cycle reads buffer[rd_ptr], increments rd_ptr mod DEPTH and read count; rd_data/rd_valid appear exactly 1 cycle after rd_en.
REQ-023 After the DEPTH-th accepted read -> IDLE; done drops the next cycle; final rd_valid still issues one cycle later.
REQ-024 rd_en outside DONE SHALL be ignored (no rd_valid); rd_valid SHALL be 0 whenever no read was accepted the prior cycle.
REQ-025 Readout order: PRE_WORDS pre-trigger words (oldest first), then trigger word, then post words.
REQ-026 Arithmetic on pointers/counters SHALL be unsigned, width DEPTH_LOG2 (+1 for counts up to DEPTH).

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, rd_valid=0, rd_data=0, trig_addr=0, trig_d=0, pointers/counts=0.
REQ-028 Buffer contents need not be reset; reset mid-capture or mid-readout SHALL abandon it and require a new arm.

Verification
REQ-029 Ramp datain (word n = n), arm, trigger edge at word 40 -> trig_addr=40, done after word 87, 64 reads return 24..87 in order.
REQ-030 trigin already high when armed, held high -> no trigger, stays ARMED; drop then raise at word 100 -> trigger word 100, trig_addr=100 mod 64=36.
REQ-031 Trigger edge at word 5 (inside PREFILL) ignored; next edge at word 20 -> readout 4..67.
REQ-032 Wrap: trigger at wr_ptr=2 -> first read address (2-16) mod 64=50; read data continuous across 63->0.
REQ-033 Extra arm during POST and rd_en during ARMED -> no state change, rd_valid stays 0; gapped rd_en in DONE -> rd_valid tracks each accepted read with 1-cycle latency.
REQ-034 rst_n pulse low in POST -> all outputs at reset values same cycle; subsequent arm runs a clean capture.

Source files
------------

// File: rtl/trig_capture.sv
// Trigger-based capture buffer.
// Streams 128-bit sample words into a circular buffer once armed, keeps
// PRE_WORDS words of history before a rising edge on trigin, fills the rest
// of the buffer after it, then plays the whole buffer back oldest-first.
//
// Ports:
//   clkin      : single clock, all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   datain     : 128-bit sample word (16 x 8-bit samples)
//   trigin     : trigger level; an event is a 0->1 transition
//   arm        : single-cycle capture request, honoured only in IDLE
//   rd_en      : readout request, one word per cycle, honoured only in DONE
//   rd_data    : word read out, valid one cycle after the accepted rd_en
//   rd_valid   : rd_data valid this cycle
//   busy       : capture in progress (PREFILL, ARMED, POST)
//   done       : capture complete, readout pending
//   trig_addr  : buffer address holding the trigger word
module trig_capture #(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned PRE_WORDS  = 16
) (
  input  logic                  clkin,
  input  logic                  rst_n,
  input  logic [127:0]          datain,
  input  logic                  trigin,
  input  logic                  arm,
  input  logic                  rd_en,
  output logic [127:0]          rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_addr
);

  localparam int unsigned DW         = 128;
  localparam int unsigned AW         = DEPTH_LOG2;
  localparam int unsigned CW         = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned POST_WORDS = DEPTH - PRE_WORDS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_trig_d;
  logic [AW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0]   r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [AW-1:0]   r_trig_addr, w_trig_addr_nxt;
  logic [DW-1:0]   r_rd_data, w_rd_data_nxt;
  logic            r_rd_valid, w_rd_valid_nxt;
  logic            r_busy, r_done;
  logic            w_wr_en;
  logic            w_trig_evt;
  logic [DW-1:0]   r_mem [DEPTH];

  assign w_trig_evt = trigin & ~r_trig_d;

  // Next-state and datapath update; r_cnt is shared as fill, post and read count.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_cnt_nxt       = r_cnt;
    w_trig_addr_nxt = r_trig_addr;
    w_rd_data_nxt   = r_rd_data;
    w_rd_valid_nxt  = 1'b0;
    w_wr_en         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (arm) begin
          w_state_nxt  = S_PREFILL;
          w_wr_ptr_nxt = '0;
          w_cnt_nxt    = '0;
        end
      end
      S_PREFILL: begin
        w_wr_en      = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
        w_cnt_nxt    = r_cnt + CW'(1);
        if (r_cnt == CW'(PRE_WORDS - 1)) begin
          w_state_nxt = S_ARMED;
          w_cnt_nxt   = '0;
        end
      end
      S_ARMED: begin
        w_wr_en      = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
        if (w_trig_evt) begin
          w_trig_addr_nxt = r_wr_ptr;
          // The trigger word itself is the first post-trigger write.
          w_cnt_nxt       = CW'(1);
          if (POST_WORDS == 1) begin
            w_state_nxt  = S_DONE;
            w_rd_ptr_nxt = r_wr_ptr - AW'(PRE_WORDS);
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt  = S_POST;
          end
        end
      end
      S_POST: begin
        w_wr_en      = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
        w_cnt_nxt    = r_cnt + CW'(1);
        if (r_cnt == CW'(POST_WORDS - 1)) begin
          w_state_nxt  = S_DONE;
          // Oldest pre-trigger word; modulo wrap comes from the AW-bit width.
          w_rd_ptr_nxt = r_trig_addr - AW'(PRE_WORDS);
          w_cnt_nxt    = '0;
        end
      end
      S_DONE: begin
        if (rd_en) begin
          w_rd_valid_nxt = 1'b1;
          w_rd_data_nxt  = r_mem[r_rd_ptr];
          w_rd_ptr_nxt   = r_rd_ptr + AW'(1);
          w_cnt_nxt      = r_cnt + CW'(1);
          if (r_cnt == CW'(DEPTH - 1)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_trig_d    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_trig_addr <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_trig_d    <= trigin;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_trig_addr <= w_trig_addr_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_busy      <= (w_state_nxt == S_PREFILL) || (w_state_nxt == S_ARMED) ||
                     (w_state_nxt == S_POST);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  // Capture storage; contents are don't-care after reset.
  always_ff @(posedge clkin) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= datain;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign trig_addr = r_trig_addr;

endmodule

// File: tb/tb_trig_capture.sv
// Self-checking bench for trig_capture: ramp captures with varied trigger
// placement, ignored arm/rd_en, gapped readout, wrap and mid-capture reset.
module tb_trig_capture;

  localparam int unsigned DL  = 6;
  localparam int unsigned PRE = 16;

  logic         clkin = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] datain = '0;
  logic         trigin = 1'b0;
  logic         arm = 1'b0;
  logic         rd_en = 1'b0;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         busy;
  logic         done;
  logic [DL-1:0] trig_addr;

  trig_capture #(.DEPTH_LOG2(DL), .PRE_WORDS(PRE)) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .datain    (datain),
    .trigin    (trigin),
    .arm       (arm),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .trig_addr (trig_addr)
  );

  always #5 clkin = ~clkin;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [127:0]  exp_q[$];
  logic          exp_vld = 1'b0;
  logic [7:0]    cur_tag = 8'h00;
  int unsigned   wcnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs of the previous rising edge, then drive inputs.
  task automatic step(input logic a, input logic t, input logic r, input logic acc);
    @(negedge clkin);
    chk("rd_valid", {127'd0, rd_valid}, {127'd0, exp_vld});
    if (rd_valid && exp_q.size() != 0) chk("rd_data", rd_data, exp_q.pop_front());
    arm    = a;
    trigin = t;
    rd_en  = r;
    datain = {cur_tag, 120'(wcnt)};
    wcnt++;
    exp_vld = acc;
  endtask

  function automatic logic trig_of(input int mode, input int w, input int tw);
    case (mode)
      1:       return (w != tw - 1);
      2:       return ((w >= 5) && (w < 10)) || (w >= tw);
      default: return (w >= tw);
    endcase
  endfunction

  // mode 0: plain edge at tw (plus a stray arm in POST)
  // mode 1: trigin high from before arm, dropped at tw-1 (plus rd_en in ARMED)
  // mode 2: edge in PREFILL at word 5, real edge at tw
  task automatic run_capture(input logic [7:0] tg, input int tw, input int mode);
    logic a, r;
    cur_tag = tg;
    step(1'b1, (mode == 1), 1'b0, 1'b0);
    wcnt = 0;
    for (int w = 0; w <= tw + 48; w++) begin
      a = (mode == 0) && (w == tw + 10);
      r = (mode == 1) && (w % 7 == 3) && (w < tw);
      step(a, trig_of(mode, w, tw), r, 1'b0);
      chk($sformatf("done_w%0d", w), {127'd0, done}, {127'd0, (w == tw + 48)});
      chk($sformatf("busy_w%0d", w), {127'd0, busy}, {127'd0, (w != tw + 48)});
    end
    chk("trig_addr", 128'(trig_addr), 128'(tw % 64));
  endtask

  task automatic readout(input logic [7:0] tg, input int tw, input logic gapped);
    int   k;
    int   guard;
    logic r;
    k = 0;
    guard = 0;
    while (k < 64 && guard < 400) begin
      r = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r) begin
        exp_q.push_back({tg, 120'(tw - 16 + k)});
        k++;
      end
      step(1'b0, 1'b0, r, r);
      chk("done_rd", {127'd0, done}, 128'd1);
      guard++;
    end
    if (k < 64) chk("readout_timeout", 128'(k), 128'd64);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_after_rd", {127'd0, done}, 128'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_busy", {127'd0, busy}, 128'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rd_q_empty", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},  {127'd0, busy},     128'd0);
    chk({tag, "_done"},  {127'd0, done},     128'd0);
    chk({tag, "_rdv"},   {127'd0, rd_valid}, 128'd0);
    chk({tag, "_rdd"},   rd_data,            128'd0);
    chk({tag, "_taddr"}, 128'(trig_addr),    128'd0);
  endtask

  initial begin
    repeat (3) @(negedge clkin);
    check_reset_vals("rst0");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Basic ramp, trigger at word 40, stray arm during POST.
    run_capture(8'h11, 40, 0);
    readout(8'h11, 40, 1'b0);

    // Trigger held high across arm; only the later edge at word 100 counts.
    run_capture(8'h22, 100, 1);
    readout(8'h22, 100, 1'b0);

    // Edge inside PREFILL ignored; gapped readout.
    run_capture(8'h33, 20, 2);
    readout(8'h33, 20, 1'b1);

    // Reset in the middle of POST abandons the capture.
    cur_tag = 8'h44;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wcnt = 0;
    for (int w = 0; w < 50; w++) step(1'b0, (w >= 30), 1'b0, 1'b0);
    chk("pre_rst_taddr", 128'(trig_addr), 128'd30);
    chk("pre_rst_busy", {127'd0, busy}, 128'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("rst1");
    exp_vld = 1'b0;
    @(negedge clkin);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_busy", {127'd0, busy}, 128'd0);

    // Clean capture after reset; trigger at address 2 forces readout wrap.
    run_capture(8'h55, 66, 0);
    readout(8'h55, 66, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
